// File: rtl/mmu_pkg.sv
// Shared definitions for the Sv32 page-table walker:
// PTE field positions, walker states and address helpers.
package mmu_pkg;

   localparam int PTE_V = 0;
   localparam int PTE_R = 1;
   localparam int PTE_W = 2;
   localparam int PTE_X = 3;
   localparam int PTE_U = 4;
   localparam int PTE_G = 5;
   localparam int PTE_A = 6;
   localparam int PTE_D = 7;

   localparam int PPN0_LSB = 10;
   localparam int PPN0_MSB = 19;
   localparam int PPN1_LSB = 20;
   localparam int PPN1_MSB = 31;

   localparam int PTE_SIZE_LOG2 = 2;
   localparam int PAGE_OFFSET   = 12;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_L1   = 2'd1;
   localparam logic [1:0] ST_L0   = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_L1   = ST_L1,
      S_L0   = ST_L0,
      S_RESP = ST_RESP
   } ptw_state_e;

   function automatic logic [31:0] pte_addr(
      input logic [19:0] ppn,
      input logic [9:0]  idx
   );
      return (32'(ppn) << PAGE_OFFSET)
           + (32'(idx) << PTE_SIZE_LOG2);
   endfunction

endpackage

// File: rtl/mmu_pte_check.sv
// Classifies a fetched PTE: invalid encoding, leaf,
// and misaligned megapage (leaf at level 1 with PPN0 set).
module mmu_pte_check
   import mmu_pkg::*;
(
   input  logic [3:0] flags,
   input  logic [1:0] hi,
   input  logic [9:0] ppn0,
   input  logic       level,
   output logic       invalid,
   output logic       leaf,
   output logic       misaligned
);

   assign invalid = !flags[PTE_V]
                  | (!flags[PTE_R] & flags[PTE_W])
                  | (|hi);

   assign leaf = flags[PTE_R] | flags[PTE_X];

   assign misaligned = level & leaf & (|ppn0);

endmodule

// File: rtl/mmu_ptw.sv
// Sv32 two-level page-table walker refilling mmu_tlb.
// One walk in flight; flush aborts after the outstanding read.
module mmu_ptw
   import mmu_pkg::*;
#(
   parameter int PPN_SIZE = 20
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [PPN_SIZE-1:0] satp_ppn_i,
   input  logic                walk_req_i,
   input  logic [PPN_SIZE-1:0] walk_vpn_i,
   input  logic                flush_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                fault_o,
   output logic                tlb_update_o,
   output logic [PPN_SIZE-1:0] tlb_vpn_o,
   output logic [31:0]         tlb_entry_o,
   output logic                mem_req_o,
   output logic [31:0]         mem_addr_o,
   input  logic                mem_ack_i,
   input  logic [31:0]         mem_rdata_i,
   input  logic                mem_err_i
);

   localparam int HALF = PPN_SIZE / 2;

   ptw_state_e          state_q, state_d;
   logic [PPN_SIZE-1:0] vpn_q, vpn_d;
   logic [31:0]         entry_q, entry_d;
   logic                abort_q, abort_d;
   logic                fault_q, fault_d;
   logic                req_d;
   logic [31:0]         addr_d;

   logic pte_invalid, pte_leaf, pte_misaligned;

   mmu_pte_check u_check (
      .flags      (mem_rdata_i[3:0]),
      .hi         (mem_rdata_i[31:30]),
      .ppn0       (mem_rdata_i[PPN0_MSB:PPN0_LSB]),
      .level      (state_q == S_L1),
      .invalid    (pte_invalid),
      .leaf       (pte_leaf),
      .misaligned (pte_misaligned)
   );

   always_comb begin
      state_d = state_q;
      vpn_d   = vpn_q;
      entry_d = entry_q;
      fault_d = fault_q;
      req_d   = mem_req_o;
      addr_d  = mem_addr_o;
      abort_d = abort_q | (flush_i & (state_q == S_L1 || state_q == S_L0));
      unique case (state_q)
         S_IDLE: begin
            abort_d = 1'b0;
            if (walk_req_i && !flush_i) begin
               state_d = S_L1;
               vpn_d   = walk_vpn_i;
               req_d   = 1'b1;
               addr_d  = pte_addr(satp_ppn_i,
                                  walk_vpn_i[PPN_SIZE-1:HALF]);
            end
         end
         S_L1, S_L0: begin
            if (mem_ack_i) begin
               req_d   = 1'b0;
               state_d = S_RESP;
               fault_d = 1'b1;
               if (abort_d) begin
                  state_d = S_IDLE;
                  abort_d = 1'b0;
               end else if (mem_err_i || pte_invalid
                            || pte_misaligned) begin
                  fault_d = 1'b1;
               end else if (pte_leaf) begin
                  fault_d = 1'b0;
                  // megapage: low VPN bits become PPN0 of the 4 KiB entry
                  entry_d = (state_q == S_L1)
                          ? {mem_rdata_i[PPN1_MSB:PPN1_LSB],
                             vpn_q[HALF-1:0],
                             mem_rdata_i[PPN0_LSB-1:0]}
                          : mem_rdata_i;
               end else if (state_q == S_L1) begin
                  state_d = S_L0;
                  req_d   = 1'b1;
                  addr_d  = pte_addr(mem_rdata_i[29:10],
                                     vpn_q[HALF-1:0]);
               end
            end
         end
         S_RESP: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= S_IDLE;
         vpn_q      <= '0;
         entry_q    <= '0;
         abort_q    <= 1'b0;
         fault_q    <= 1'b0;
         mem_req_o  <= 1'b0;
         mem_addr_o <= '0;
      end else begin
         state_q    <= state_d;
         vpn_q      <= vpn_d;
         entry_q    <= entry_d;
         abort_q    <= abort_d;
         fault_q    <= fault_d;
         mem_req_o  <= req_d;
         mem_addr_o <= addr_d;
      end
   end

   logic resp;
   assign resp = (state_q == S_RESP) & !flush_i;

   assign busy_o       = (state_q != S_IDLE);
   assign done_o       = resp;
   assign fault_o      = resp & fault_q;
   assign tlb_update_o = resp & !fault_q;
   assign tlb_vpn_o    = vpn_q;
   assign tlb_entry_o  = entry_q;

endmodule
